// File: rtl/mem_pattern_tester.sv
// mem_pattern_tester: writes an LFSR pattern across N words of a word memory,
// reads it back and counts mismatches.
//
// Optional feature: define MEM_PATTERN_TESTER_ABORT_EN to stop the read pass
// at the first mismatch. Left undefined, every word is always read back.
//
// Ports
//   clk_i, rst_n_i      clock, async active-low reset
//   start_i             run request (only looked at in IDLE)
//   base_addr_i         byte base address (low two bits ignored)
//   num_words_i         words to test (0 => immediate pass)
//   seed_i              LFSR seed (0 is replaced by 1)
//   busy_o, done_o      run in progress / one-cycle completion pulse
//   pass_o              last run had no mismatches
//   err_count_o         saturating mismatch count of the last run
//   first_err_addr_o    byte address of the first mismatch
//   addr_o, write_en_o, data_o, data_i   memory port (data_i is combinational)
module mem_pattern_tester #(
    parameter int CNT_W = 13
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [31:0]      base_addr_i,
    input  logic [CNT_W-1:0] num_words_i,
    input  logic [31:0]      seed_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [31:0]      first_err_addr_o,
    output logic [31:0]      addr_o,
    output logic             write_en_o,
    output logic [31:0]      data_o,
    input  logic [31:0]      data_i
);

`ifdef MEM_PATTERN_TESTER_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    localparam logic [31:0] TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q, n_q, err_q;
    logic [31:0]      base_q, seed_q, lfsr_q, addr_q, data_q, ferr_q;
    logic             we_q, busy_q, done_q, pass_q;

    logic [31:0]      lfsr_d, seed_d, base_d;
    logic [CNT_W-1:0] err_d;
    logic             mismatch, last_word;

    // Galois LFSR, right shift: the bit shifted out selects the tap mask.
    always_comb begin
        lfsr_d    = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
        seed_d    = (seed_i == 32'h0) ? 32'h1 : seed_i;
        base_d    = {base_addr_i[31:2], 2'b00};
        mismatch  = (data_i != lfsr_q);
        last_word = (cnt_q == n_q - CNT_W'(1));
        err_d     = err_q;
        if (mismatch && !(&err_q))
            err_d = err_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            err_q   <= '0;
            base_q  <= '0;
            seed_q  <= '0;
            lfsr_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            ferr_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        err_q  <= '0;
                        ferr_q <= '0;
                        if (num_words_i != '0) begin
                            base_q  <= base_d;
                            n_q     <= num_words_i;
                            seed_q  <= seed_d;
                            lfsr_q  <= seed_d;
                            // Word 0 is presented in the first WRITE cycle.
                            data_q  <= seed_d;
                            addr_q  <= base_d;
                            cnt_q   <= '0;
                            we_q    <= 1'b1;
                            busy_q  <= 1'b1;
                            pass_q  <= 1'b0;
                            state_q <= S_WRITE;
                        end else begin
                            pass_q  <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_WRITE: begin
                    if (last_word) begin
                        // Rewind to word 0 for the read-back pass.
                        we_q    <= 1'b0;
                        addr_q  <= base_q;
                        lfsr_q  <= seed_q;
                        cnt_q   <= '0;
                        state_q <= S_READ;
                    end else begin
                        addr_q <= addr_q + 32'd4;
                        lfsr_q <= lfsr_d;
                        data_q <= lfsr_d;
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end
                end
                S_READ: begin
                    err_q <= err_d;
                    if (mismatch && err_q == '0)
                        ferr_q <= addr_q;
                    if (last_word || (ABORT_EN && mismatch)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        // err_d includes the compare made on this edge.
                        pass_q  <= (err_d == '0);
                        state_q <= S_DONE;
                    end else begin
                        addr_q <= addr_q + 32'd4;
                        lfsr_q <= lfsr_d;
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_count_o      = err_q;
    assign first_err_addr_o = ferr_q;
    assign addr_o           = addr_q;
    assign write_en_o       = we_q;
    assign data_o           = data_q;

endmodule

// File: tb/tb_mem_pattern_tester.sv
// Bench for mem_pattern_tester: 16 KB word memory model with an optional
// stuck-at-0 fault on write bit 0, expected traffic queued per run.
module tb_mem_pattern_tester;
    localparam int CNT_W = 13;

    logic             clk_i = 1'b0;
    logic             rst_n_i = 1'b0;
    logic             start_i = 1'b0;
    logic [31:0]      base_addr_i = '0;
    logic [CNT_W-1:0] num_words_i = '0;
    logic [31:0]      seed_i = '0;
    logic             busy_o, done_o, pass_o, write_en_o;
    logic [CNT_W-1:0] err_count_o;
    logic [31:0]      first_err_addr_o, addr_o, data_o, data_i;

    mem_pattern_tester #(.CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i),
        .base_addr_i(base_addr_i), .num_words_i(num_words_i), .seed_i(seed_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
        .err_count_o(err_count_o), .first_err_addr_o(first_err_addr_o),
        .addr_o(addr_o), .write_en_o(write_en_o), .data_o(data_o), .data_i(data_i)
    );

    always #5 clk_i = ~clk_i;

    logic [31:0] mem [0:4095];
    logic        fault = 1'b0;
    assign data_i = mem[addr_o[13:2]];
    always @(posedge clk_i)
        if (write_en_o) mem[addr_o[13:2]] <= fault ? {data_o[31:1], 1'b0} : data_o;

    int checks = 0;
    int passed = 0;

    logic [63:0] exp_wr[$], obs_wr[$];
    logic [31:0] exp_rd[$], obs_rd[$];
    int done_cyc, busy_cyc;

    function automatic logic [31:0] lstep(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Queue the expected write and read traffic of one run.
    task automatic push_expected(input logic [31:0] base, input int n, input logic [31:0] seed);
        logic [31:0] s, a;
        s = (seed == 0) ? 32'h1 : seed;
        exp_wr.delete();
        exp_rd.delete();
        for (int k = 0; k < n; k++) begin
            a = {base[31:2], 2'b00} + 32'(4 * k);
            exp_wr.push_back({a, s});
            exp_rd.push_back(a);
            s = lstep(s);
        end
    endtask

    // Start one run from IDLE and record the DUT's traffic until done_o.
    // Cycle 1 is the cycle right after the start edge.
    task automatic run(input logic [31:0] base, input int n, input logic [31:0] seed,
                       input int pulse_cyc, input int max_cyc);
        obs_wr.delete();
        obs_rd.delete();
        done_cyc = -1;
        busy_cyc = 0;
        @(negedge clk_i);
        base_addr_i = base;
        num_words_i = CNT_W'(n);
        seed_i      = seed;
        start_i     = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk_i);
            if (busy_o) busy_cyc++;
            if (write_en_o) obs_wr.push_back({addr_o, data_o});
            else if (busy_o) obs_rd.push_back(addr_o);
            if (done_o) begin
                done_cyc = c;
                break;
            end
            start_i = (c == pulse_cyc);
            if (c == pulse_cyc) begin
                base_addr_i = 32'h4000;
                num_words_i = CNT_W'(2);
            end
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({busy_o, done_o, pass_o, write_en_o, addr_o, data_o, err_count_o, first_err_addr_o} !== '0)
            $display("FAIL reset_outputs: got busy=%b done=%b pass=%b we=%b addr=%h data=%h err=%0d ferr=%h want all 0",
                     busy_o, done_o, pass_o, write_en_o, addr_o, data_o, err_count_o, first_err_addr_o);
        else passed++;
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic test_basic;
        logic [63:0] e, o;
        push_expected(32'h100, 4, 32'h1);
        run(32'h100, 4, 32'h1, 0, 40);
        checks++; if (done_cyc !== 9) $display("FAIL basic_done_cycle: got %0d want 9", done_cyc); else passed++;
        checks++; if (busy_cyc !== 8) $display("FAIL basic_busy_cycles: got %0d want 8", busy_cyc); else passed++;
        checks++; if (pass_o !== 1'b1) $display("FAIL basic_pass: got %b want 1", pass_o); else passed++;
        checks++; if (err_count_o !== 0) $display("FAIL basic_err: got %0d want 0", err_count_o); else passed++;
        checks++;
        if (obs_wr.size() < 2 || obs_wr[1][31:0] !== 32'h8020_0003)
            $display("FAIL basic_word1_data: got %0d writes, want word1 80200003", obs_wr.size());
        else passed++;
        while (exp_wr.size() != 0) begin
            e = exp_wr.pop_front();
            checks++;
            if (obs_wr.size() == 0) $display("FAIL basic_write_missing: want %h", e);
            else begin
                o = obs_wr.pop_front();
                if (o !== e) $display("FAIL basic_write: got %h want %h", o, e); else passed++;
            end
        end
        checks++; if (obs_rd !== exp_rd) $display("FAIL basic_read_addrs: got %p want %p", obs_rd, exp_rd); else passed++;
    endtask

    task automatic test_fault;
        int exp_err, exp_done, exp_nrd;
`ifdef MEM_PATTERN_TESTER_ABORT_EN
        exp_err = 1; exp_done = 6; exp_nrd = 1;
`else
        // Patterns 1, 80200003, C0300002, 60180001: three are odd.
        exp_err = 3; exp_done = 9; exp_nrd = 4;
`endif
        fault = 1'b1;
        run(32'h100, 4, 32'h1, 0, 40);
        fault = 1'b0;
        checks++; if (done_cyc !== exp_done) $display("FAIL fault_done_cycle: got %0d want %0d", done_cyc, exp_done); else passed++;
        checks++; if (err_count_o !== CNT_W'(exp_err)) $display("FAIL fault_err: got %0d want %0d", err_count_o, exp_err); else passed++;
        checks++; if (first_err_addr_o !== 32'h100) $display("FAIL fault_first_addr: got %h want 100", first_err_addr_o); else passed++;
        checks++; if (pass_o !== 1'b0) $display("FAIL fault_pass: got %b want 0", pass_o); else passed++;
        checks++; if (obs_rd.size() !== exp_nrd) $display("FAIL fault_read_count: got %0d want %0d", obs_rd.size(), exp_nrd); else passed++;
        // Results hold through IDLE.
        repeat (3) @(negedge clk_i);
        checks++;
        if (err_count_o !== CNT_W'(exp_err) || first_err_addr_o !== 32'h100 || pass_o !== 1'b0 || done_o !== 1'b0)
            $display("FAIL fault_hold: got err=%0d ferr=%h pass=%b done=%b want %0d 100 0 0",
                     err_count_o, first_err_addr_o, pass_o, done_o, exp_err);
        else passed++;
    endtask

    task automatic test_zero_len;
        run(32'h800, 0, 32'h9, 0, 10);
        checks++; if (done_cyc !== 1) $display("FAIL zero_len_done_cycle: got %0d want 1", done_cyc); else passed++;
        checks++; if (obs_wr.size() !== 0) $display("FAIL zero_len_writes: got %0d want 0", obs_wr.size()); else passed++;
        checks++;
        if (pass_o !== 1'b1 || err_count_o !== 0 || busy_cyc !== 0)
            $display("FAIL zero_len_result: got pass=%b err=%0d busy=%0d want 1 0 0", pass_o, err_count_o, busy_cyc);
        else passed++;
    endtask

    task automatic test_zero_seed;
        logic [63:0] e, o;
        push_expected(32'h400, 5, 32'h1);
        run(32'h400, 5, 32'h0, 0, 40);
        checks++; if (pass_o !== 1'b1 || done_cyc !== 11) $display("FAIL zero_seed_result: got pass=%b done=%0d want 1 11", pass_o, done_cyc); else passed++;
        while (exp_wr.size() != 0) begin
            e = exp_wr.pop_front();
            checks++;
            if (obs_wr.size() == 0) $display("FAIL zero_seed_write_missing: want %h", e);
            else begin
                o = obs_wr.pop_front();
                if (o !== e) $display("FAIL zero_seed_write: got %h want %h", o, e); else passed++;
            end
        end
    endtask

    task automatic test_wrap;
        logic [63:0] e, o;
        push_expected(32'hFFFF_FFF8, 4, 32'hDEAD_BEEF);
        run(32'hFFFF_FFFB, 4, 32'hDEAD_BEEF, 0, 40);  // low bits must be ignored
        checks++; if (pass_o !== 1'b1 || err_count_o !== 0) $display("FAIL wrap_result: got pass=%b err=%0d want 1 0", pass_o, err_count_o); else passed++;
        while (exp_wr.size() != 0) begin
            e = exp_wr.pop_front();
            checks++;
            if (obs_wr.size() == 0) $display("FAIL wrap_write_missing: want %h", e);
            else begin
                o = obs_wr.pop_front();
                if (o !== e) $display("FAIL wrap_write: got %h want %h", o, e); else passed++;
            end
        end
        checks++; if (obs_rd !== exp_rd) $display("FAIL wrap_read_addrs: got %p want %p", obs_rd, exp_rd); else passed++;
    endtask

    task automatic test_mid_reset;
        @(negedge clk_i);
        base_addr_i = 32'h200; num_words_i = CNT_W'(8); seed_i = 32'h5; start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        checks++; if (write_en_o !== 1'b1 || addr_o !== 32'h208) $display("FAIL mid_reset_precond: got we=%b addr=%h want 1 208", write_en_o, addr_o); else passed++;
        rst_n_i = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, pass_o, write_en_o, addr_o, data_o, err_count_o, first_err_addr_o} !== '0)
            $display("FAIL mid_reset_outputs: got busy=%b we=%b addr=%h data=%h pass=%b want all 0",
                     busy_o, write_en_o, addr_o, data_o, pass_o);
        else passed++;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        run(32'h200, 8, 32'h5, 0, 60);
        checks++;
        if (done_cyc !== 17 || pass_o !== 1'b1 || err_count_o !== 0)
            $display("FAIL mid_reset_restart: got done=%0d pass=%b err=%0d want 17 1 0", done_cyc, pass_o, err_count_o);
        else passed++;
    endtask

    task automatic test_start_ignored;
        logic [63:0] e, o;
        push_expected(32'h300, 4, 32'h1234);
        run(32'h300, 4, 32'h1234, 2, 40);
        checks++; if (done_cyc !== 9 || pass_o !== 1'b1) $display("FAIL start_ignored_result: got done=%0d pass=%b want 9 1", done_cyc, pass_o); else passed++;
        while (exp_wr.size() != 0) begin
            e = exp_wr.pop_front();
            checks++;
            if (obs_wr.size() == 0) $display("FAIL start_ignored_write_missing: want %h", e);
            else begin
                o = obs_wr.pop_front();
                if (o !== e) $display("FAIL start_ignored_write: got %h want %h", o, e); else passed++;
            end
        end
        checks++; if (obs_wr.size() !== 0) $display("FAIL start_ignored_extra_writes: got %0d want 0", obs_wr.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fault();
        test_zero_len();
        test_zero_seed();
        test_wrap();
        test_mid_reset();
        test_start_ignored();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
